// File: rtl/pio_rrsp_arb.sv
// pio_rrsp_arb: merges the read-response streams of the PIO BAR access
// engines into one completer read-response channel. Sources are picked
// round-robin, a picked source owns the channel until its last beat, and the
// merged stream leaves through a single registered output stage.
// Optional feature macro: PIO_RRSP_ARB_STAT_EN adds per-source packet counters
// on port rrsp_pkt_cnt.
`ifndef PIO_DATA_W
`define PIO_DATA_W 256
`endif
`ifndef PIO_HEAD_W
`define PIO_HEAD_W 132
`endif

module pio_rrsp_arb #(
  parameter int CHNL_NUM = 3,
  parameter int DATA_W   = `PIO_DATA_W,
  parameter int HEAD_W   = `PIO_HEAD_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHNL_NUM*DATA_W-1:0] in_rrsp_data,
  input  logic [CHNL_NUM*HEAD_W-1:0] in_rrsp_head,
  input  logic [CHNL_NUM-1:0]        in_rrsp_last,
  input  logic [CHNL_NUM-1:0]        in_rrsp_valid,
  output logic [CHNL_NUM-1:0]        in_rrsp_ready,
  output logic [DATA_W-1:0]          out_rrsp_data,
  output logic [HEAD_W-1:0]          out_rrsp_head,
  output logic                       out_rrsp_last,
  output logic                       out_rrsp_valid,
`ifdef PIO_RRSP_ARB_STAT_EN
  input  logic                       out_rrsp_ready,
  output logic [CHNL_NUM*16-1:0]     rrsp_pkt_cnt
`else
  input  logic                       out_rrsp_ready
`endif
);

  localparam int PTR_W = (CHNL_NUM > 1) ? $clog2(CHNL_NUM) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [PTR_W-1:0]     r_grant;
  logic [PTR_W-1:0]     r_rrPtr;
  logic [PTR_W-1:0]     w_pick;
  logic [PTR_W-1:0]     w_grantInc;
  logic [PTR_W:0]       w_sum;
  logic [CHNL_NUM-1:0]  w_validRot;
  logic                 w_found;
  logic                 w_slotFree;
  logic                 w_inFire;
  logic                 w_inLast;
  logic [DATA_W-1:0]    w_data [CHNL_NUM];
  logic [HEAD_W-1:0]    w_head [CHNL_NUM];
  logic [DATA_W-1:0]    r_outData;
  logic [HEAD_W-1:0]    r_outHead;
  logic                 r_outLast;
  logic                 r_outValid;

  for (genvar gi = 0; gi < CHNL_NUM; gi++) begin : g_slice
    assign w_data[gi] = in_rrsp_data[gi*DATA_W +: DATA_W];
    assign w_head[gi] = in_rrsp_head[gi*HEAD_W +: HEAD_W];
  end

  // Rotating the valid vector puts the round-robin start point at bit 0, so
  // the lowest set bit is the winner; its offset is added back onto the pointer.
  assign w_validRot = CHNL_NUM'({in_rrsp_valid, in_rrsp_valid} >> r_rrPtr);

  // Scan from the highest offset down so the lowest valid offset is kept last.
  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = CHNL_NUM - 1; k >= 0; k--) begin
      if (w_validRot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rrPtr} + (PTR_W+1)'(k);
      end
    end
  end

  assign w_pick = (w_sum >= (PTR_W+1)'(CHNL_NUM)) ? PTR_W'(w_sum - (PTR_W+1)'(CHNL_NUM))
                                                  : PTR_W'(w_sum);
  assign w_grantInc = (r_grant == PTR_W'(CHNL_NUM - 1)) ? '0 : r_grant + 1'b1;

  // The output register can take a beat when it is empty or being drained now.
  assign w_slotFree = !r_outValid | out_rrsp_ready;
  assign w_inFire   = (r_state == LOCK) & in_rrsp_valid[r_grant] & w_slotFree;
  assign w_inLast   = in_rrsp_last[r_grant];

  // Only the locked source ever sees ready, and only when the slot is free.
  always_comb begin
    in_rrsp_ready = '0;
    if (r_state == LOCK) begin
      in_rrsp_ready[r_grant] = w_slotFree;
    end
  end

  // Next state: lock onto a winner from IDLE, release after the last beat.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_found) w_nextState = LOCK;
      LOCK:    if (w_inFire && w_inLast) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Grant is captured on arbitration; the pointer moves past the source that just finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_rrPtr <= '0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_grant <= w_pick;
      end
      if (w_inFire && w_inLast) begin
        r_rrPtr <= w_grantInc;
      end
    end
  end

  // Output stage: reload on every accepted input beat, otherwise empty once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outData  <= '0;
      r_outHead  <= '0;
      r_outLast  <= 1'b0;
      r_outValid <= 1'b0;
    end else if (w_inFire) begin
      r_outData  <= w_data[r_grant];
      r_outHead  <= w_head[r_grant];
      r_outLast  <= w_inLast;
      r_outValid <= 1'b1;
    end else if (out_rrsp_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_rrsp_data  = r_outData;
  assign out_rrsp_head  = r_outHead;
  assign out_rrsp_last  = r_outLast;
  assign out_rrsp_valid = r_outValid;

`ifdef PIO_RRSP_ARB_STAT_EN
  logic [15:0] r_pktCnt [CHNL_NUM];

  // Count completed packets per source; the 16-bit counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHNL_NUM; i++) begin
        r_pktCnt[i] <= '0;
      end
    end else if (w_inFire && w_inLast) begin
      r_pktCnt[r_grant] <= r_pktCnt[r_grant] + 16'd1;
    end
  end

  for (genvar gc = 0; gc < CHNL_NUM; gc++) begin : g_cnt
    assign rrsp_pkt_cnt[gc*16 +: 16] = r_pktCnt[gc];
  end
`endif

endmodule

// File: tb/tb_pio_rrsp_arb.sv
// tb_pio_rrsp_arb: drives pio_rrsp_arb with directed and random response
// packets and compares every cycle against a behavioural arbiter model.
// Build with PIO_RRSP_ARB_STAT_EN to also compare the packet counters.
module tb_pio_rrsp_arb;

  localparam int N  = 3;
  localparam int DW = 256;
  localparam int HW = 132;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] inData;
  logic [N*HW-1:0] inHead;
  logic [N-1:0]    inLast;
  logic [N-1:0]    inValid;
  logic [N-1:0]    in_rrsp_ready;
  logic [DW-1:0]   out_rrsp_data;
  logic [HW-1:0]   out_rrsp_head;
  logic            out_rrsp_last;
  logic            out_rrsp_valid;
  logic            outReady;
`ifdef PIO_RRSP_ARB_STAT_EN
  logic [N*16-1:0] rrsp_pkt_cnt;
`endif

  logic [DW-1:0] srcData  [N];
  logic [HW-1:0] srcHead  [N];
  logic          srcLast  [N];
  logic          srcValid [N];
  logic          fired    [N];
  int            pktLeft  [N];

  int checks;
  int failures;

  // Behavioural model state: who owns the channel, where the search starts,
  // and what the single output slot holds.
  bit            mLock;
  int            mPtr;
  int            mGrant;
  bit            mOutValid;
  logic [DW-1:0] mOutData;
  logic [HW-1:0] mOutHead;
  bit            mOutLast;
  int            mPktCnt [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign inData[g*DW +: DW] = srcData[g];
    assign inHead[g*HW +: HW] = srcHead[g];
    assign inLast[g]          = srcLast[g];
    assign inValid[g]         = srcValid[g];
  end

  pio_rrsp_arb #(.CHNL_NUM(N), .DATA_W(DW), .HEAD_W(HW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_rrsp_data   (inData),
    .in_rrsp_head   (inHead),
    .in_rrsp_last   (inLast),
    .in_rrsp_valid  (inValid),
    .in_rrsp_ready  (in_rrsp_ready),
    .out_rrsp_data  (out_rrsp_data),
    .out_rrsp_head  (out_rrsp_head),
    .out_rrsp_last  (out_rrsp_last),
    .out_rrsp_valid (out_rrsp_valid),
`ifdef PIO_RRSP_ARB_STAT_EN
    .out_rrsp_ready (outReady),
    .rrsp_pkt_cnt   (rrsp_pkt_cnt)
`else
    .out_rrsp_ready (outReady)
`endif
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [259:0] act, input logic [259:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mLock     = 1'b0;
    mPtr      = 0;
    mGrant    = 0;
    mOutValid = 1'b0;
    mOutData  = '0;
    mOutHead  = '0;
    mOutLast  = 1'b0;
    for (int s = 0; s < N; s++) mPktCnt[s] = 0;
  endtask

  function automatic logic [N-1:0] modelReady();
    logic [N-1:0] r;
    r = '0;
    if (mLock && (!mOutValid || outReady)) r[mGrant] = 1'b1;
    return r;
  endfunction

  // One clock edge of the arbiter rules, applied to the inputs the bench drives.
  task automatic modelStep();
    bit slotFree;
    bit fire;
    int idx;
    if (!rst_n) begin
      modelReset();
      return;
    end
    slotFree = !mOutValid || outReady;
    fire     = mLock && srcValid[mGrant] && slotFree;
    if (fire) begin
      mOutData      = srcData[mGrant];
      mOutHead      = srcHead[mGrant];
      mOutLast      = srcLast[mGrant];
      mOutValid     = 1'b1;
      fired[mGrant] = 1'b1;
    end else if (mOutValid && outReady) begin
      mOutValid = 1'b0;
    end
    if (!mLock) begin
      for (int k = 0; k < N; k++) begin
        idx = (mPtr + k) % N;
        if (srcValid[idx]) begin
          mGrant = idx;
          mLock  = 1'b1;
          break;
        end
      end
    end else if (fire && srcLast[mGrant]) begin
      mLock = 1'b0;
      mPtr  = (mGrant + 1) % N;
      mPktCnt[mGrant]++;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic checkOutput();
    check("out_valid", out_rrsp_valid, mOutValid);
    if (mOutValid) begin
      check("out_data", out_rrsp_data, mOutData);
      check("out_head", out_rrsp_head, mOutHead);
      check("out_last", out_rrsp_last, mOutLast);
    end
    check("in_ready", in_rrsp_ready, modelReady());
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic clearSources();
    for (int s = 0; s < N; s++) begin
      srcValid[s] = 1'b0;
      srcLast[s]  = 1'b0;
      srcData[s]  = '0;
      srcHead[s]  = '0;
      fired[s]    = 1'b0;
      pktLeft[s]  = 0;
    end
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    outReady = 1'b0;
    clearSources();
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [HW-1:0] randHead();
    logic [HW-1:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
    v[131:128] = 4'($urandom_range(15));
    return v;
  endfunction

  // Random packet sources: valid is held until accepted, gaps between beats are allowed.
  task automatic applyStimulus(input bit drain);
    for (int s = 0; s < N; s++) begin
      if (fired[s]) begin
        fired[s]    = 1'b0;
        srcValid[s] = 1'b0;
        pktLeft[s]--;
      end
      if (!srcValid[s]) begin
        if (!drain && pktLeft[s] == 0 && $urandom_range(3) == 0) pktLeft[s] = int'($urandom_range(4, 1));
        if (pktLeft[s] != 0 && (drain || $urandom_range(3) != 0)) begin
          srcValid[s] = 1'b1;
          srcData[s]  = randData();
          srcHead[s]  = randHead();
          srcLast[s]  = (pktLeft[s] == 1);
        end
      end
    end
    outReady = drain ? 1'b1 : ($urandom_range(9) < 7);
  endtask

  // Directed scenarios with hand-computed expectations, then random traffic.
  initial begin
    int nBeats;
    int order [6];
    int cyc   [6];
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    outReady = 1'b0;
    clearSources();
    modelReset();
    @(negedge clk);
    doReset();

    check("rst_out_valid", out_rrsp_valid, 1'b0);
    check("rst_in_ready", in_rrsp_ready, 3'b000);
    check("rst_out_data", out_rrsp_data, 256'h0);

    // Single-beat packet from source 1 appears two edges later, head bit-exact.
    srcValid[1] = 1'b1;
    srcData[1]  = 256'hDEADBEEF;
    srcHead[1]  = 132'h1_0000_1000_0000_0000_0000_0000_0000_0000;
    srcLast[1]  = 1'b1;
    outReady    = 1'b1;
    tick();
    check("t1_wait_valid", out_rrsp_valid, 1'b0);
    check("t1_ready", in_rrsp_ready, 3'b010);
    tick();
    check("t1_valid", out_rrsp_valid, 1'b1);
    check("t1_data", out_rrsp_data, 256'hDEADBEEF);
    check("t1_head", out_rrsp_head, 132'h1_0000_1000_0000_0000_0000_0000_0000_0000);
    check("t1_last", out_rrsp_last, 1'b1);
    srcValid[1] = 1'b0;
    fired[1]    = 1'b0;
    tick();
    check("t1_drain", out_rrsp_valid, 1'b0);

    // All sources continuously valid: pointer sits at 2, so order is 2,0,1,2,0,1.
    for (int s = 0; s < N; s++) begin
      srcValid[s] = 1'b1;
      srcLast[s]  = 1'b1;
      srcData[s]  = DW'(s);
      srcHead[s]  = '0;
    end
    nBeats = 0;
    for (int c = 0; c < 40 && nBeats < 6; c++) begin
      tick();
      if (out_rrsp_valid) begin
        order[nBeats] = int'(out_rrsp_data[1:0]);
        cyc[nBeats]   = c;
        nBeats++;
      end
    end
    check("t2_count", nBeats, 6);
    for (int i = 0; i < 6; i++) begin
      check("t2_order", order[i], (i + 2) % 3);
      if (i > 0) check("t2_gap", cyc[i] - cyc[i-1], 2);
    end
    doReset();

    // Reset in the middle of a 3-beat packet, then arbitration restarts at source 0.
    srcValid[2] = 1'b1;
    srcLast[2]  = 1'b0;
    srcData[2]  = 256'hA1;
    outReady    = 1'b1;
    tick();
    tick();
    check("t3_beat1", out_rrsp_data, 256'hA1);
    fired[2]   = 1'b0;
    srcData[2] = 256'hA2;
    tick();
    check("t3_beat2", out_rrsp_data, 256'hA2);
    rst_n = 1'b0;
    modelReset();
    fired[2] = 1'b0;
    #1;
    check("t3_rst_valid", out_rrsp_valid, 1'b0);
    check("t3_rst_ready", in_rrsp_ready, 3'b000);
    @(negedge clk);
    rst_n       = 1'b1;
    srcValid[0] = 1'b1;
    srcLast[0]  = 1'b1;
    srcData[0]  = 256'hB0;
    srcLast[2]  = 1'b1;
    tick();
    check("t3_rearb", in_rrsp_ready, 3'b001);
    tick();
    check("t3_src0", out_rrsp_data, 256'hB0);
    doReset();

    // Random traffic with random downstream backpressure.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(1'b0);
      tick();
    end
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1);
      tick();
    end
    check("drain_idle", out_rrsp_valid, 1'b0);
`ifdef PIO_RRSP_ARB_STAT_EN
    for (int s = 0; s < N; s++) begin
      check("pkt_cnt", rrsp_pkt_cnt[s*16 +: 16], 16'(mPktCnt[s]));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
